// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - decode/issue stage feeding the ID/EX pipeline register
// Optional bypass network: define ID_EX_FORWARD_EN (default build stalls on RAW instead).
module id_ex_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] ex_alu_out,
    input  logic        wb_valid,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_opcode,
    output logic [2:0]  ex_func3,
    output logic        ex_func7,
    output logic [31:0] ex_operand1,
    output logic [31:0] ex_operand2,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_illegal
);
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_ICOMP = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_B     = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    logic        ex_valid_q, ex_reg_write_q, ex_illegal_q, ex_func7_q;
    logic [4:0]  ex_opcode_q, ex_rd_q;
    logic [2:0]  ex_func3_q;
    logic [31:0] ex_operand1_q, ex_operand2_q, ex_rs1_val_q, ex_rs2_val_q;
    logic [31:0] ex_imm_q, ex_pc_q;

    logic [4:0]  opcode, rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] fwd1, fwd2;
    logic [31:0] operand1_d, operand2_d, imm_d;
    logic        known, use1_raw, use2_raw, writes, legal, use1, use2;
    logic        wb_ok, raw1, raw2, hazard, issue, bubble;

    assign opcode   = if_inst[6:2];
    assign rd       = if_inst[11:7];
    assign rs1      = if_inst[19:15];
    assign rs2      = if_inst[24:20];
    assign rs1_addr = rs1;
    assign rs2_addr = rs2;

    assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
    assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_b = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_j = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
    assign imm_u = {if_inst[31:12], 12'b0};

    assign wb_ok = wb_valid && wb_reg_write;

`ifdef ID_EX_FORWARD_EN
    logic ex_fwd_ok, ex_is_load;
    // A load's result is not in ex_alu_out yet, so it never feeds the EX bypass.
    assign ex_is_load = ex_valid_q && !ex_illegal_q && (ex_opcode_q == OP_LOAD);
    assign ex_fwd_ok  = ex_valid_q && ex_reg_write_q && !ex_is_load;

    always_comb begin
        fwd1 = rs1_data;
        if (ex_fwd_ok && ex_rd_q == rs1)  fwd1 = ex_alu_out;
        else if (wb_ok && wb_rd == rs1)   fwd1 = wb_data;
        if (rs1 == 5'd0)                  fwd1 = '0;
    end

    always_comb begin
        fwd2 = rs2_data;
        if (ex_fwd_ok && ex_rd_q == rs2)  fwd2 = ex_alu_out;
        else if (wb_ok && wb_rd == rs2)   fwd2 = wb_data;
        if (rs2 == 5'd0)                  fwd2 = '0;
    end

    assign raw1 = use1 && (rs1 != 5'd0) && ex_is_load && (ex_rd_q == rs1);
    assign raw2 = use2 && (rs2 != 5'd0) && ex_is_load && (ex_rd_q == rs2);
`else
    logic unused_bypass;
    assign unused_bypass = ^{ex_alu_out, wb_data};

    assign fwd1 = (rs1 == 5'd0) ? '0 : rs1_data;
    assign fwd2 = (rs2 == 5'd0) ? '0 : rs2_data;

    // Without a bypass, wait until neither EX nor WB still owes us the source.
    assign raw1 = use1 && (rs1 != 5'd0) &&
                  ((ex_valid_q && ex_reg_write_q && ex_rd_q == rs1) || (wb_ok && wb_rd == rs1));
    assign raw2 = use2 && (rs2 != 5'd0) &&
                  ((ex_valid_q && ex_reg_write_q && ex_rd_q == rs2) || (wb_ok && wb_rd == rs2));
`endif

    always_comb begin
        known      = 1'b1;
        use1_raw   = 1'b0;
        use2_raw   = 1'b0;
        writes     = 1'b0;
        operand1_d = fwd1;
        operand2_d = fwd2;
        imm_d      = '0;
        case (opcode)
            OP_R: begin
                use1_raw = 1'b1; use2_raw = 1'b1; writes = 1'b1;
            end
            OP_ICOMP, OP_LOAD: begin
                use1_raw = 1'b1; writes = 1'b1;
                operand2_d = imm_i; imm_d = imm_i;
            end
            OP_STORE: begin
                use1_raw = 1'b1; use2_raw = 1'b1;
                operand2_d = imm_s; imm_d = imm_s;
            end
            OP_B: begin
                use1_raw = 1'b1; use2_raw = 1'b1;
                imm_d = imm_b;
            end
            OP_JAL: begin
                writes = 1'b1;
                operand1_d = if_pc; operand2_d = imm_j; imm_d = imm_j;
            end
            OP_JALR: begin
                use1_raw = 1'b1; writes = 1'b1;
                operand1_d = if_pc; operand2_d = imm_i; imm_d = imm_i;
            end
            OP_LUI: begin
                writes = 1'b1;
                operand1_d = '0; operand2_d = imm_u; imm_d = imm_u;
            end
            OP_AUIPC: begin
                writes = 1'b1;
                operand1_d = if_pc; operand2_d = imm_u; imm_d = imm_u;
            end
            default: known = 1'b0;
        endcase
    end

    assign legal = known && (if_inst[1:0] == 2'b11);
    assign use1  = legal && use1_raw;
    assign use2  = legal && use2_raw;

    assign hazard   = if_valid && (raw1 || raw2);
    assign id_ready = flush || (!ex_stall && !hazard);
    assign issue    = !flush && !ex_stall && if_valid && !hazard;
    assign bubble   = flush || (!ex_stall && !issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_illegal_q   <= 1'b0;
            ex_opcode_q    <= '0;
            ex_func3_q     <= '0;
            ex_func7_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_operand1_q  <= '0;
            ex_operand2_q  <= '0;
            ex_rs1_val_q   <= '0;
            ex_rs2_val_q   <= '0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
        end else if (bubble) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else if (issue) begin
            ex_valid_q     <= 1'b1;
            ex_reg_write_q <= legal && writes && (rd != 5'd0);
            ex_illegal_q   <= !legal;
            ex_opcode_q    <= opcode;
            ex_func3_q     <= if_inst[14:12];
            ex_func7_q     <= if_inst[30];
            ex_rd_q        <= rd;
            ex_operand1_q  <= operand1_d;
            ex_operand2_q  <= operand2_d;
            ex_rs1_val_q   <= fwd1;
            ex_rs2_val_q   <= fwd2;
            ex_imm_q       <= imm_d;
            ex_pc_q        <= if_pc;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_illegal   = ex_illegal_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_func3     = ex_func3_q;
    assign ex_func7     = ex_func7_q;
    assign ex_rd        = ex_rd_q;
    assign ex_operand1  = ex_operand1_q;
    assign ex_operand2  = ex_operand2_q;
    assign ex_rs1_val   = ex_rs1_val_q;
    assign ex_rs2_val   = ex_rs2_val_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-and-issue stage that drives the ALU. It takes a fetched instruction with its register-file read data and decodes the opcode. It selects ALU operands (register, PC, immediate, or forwarded result), detects load-use and RAW hazards, and registers everything into the ID/EX pipeline register that feeds the ALU and the branch/memory logic in EX.

## Interface
- No parameters; datapath fixed at 32 bits, 32 architectural registers.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  instruction at ID is valid
- if_inst  in  32  instruction word
- if_pc  in  32  PC of if_inst
- id_ready  out  1  ID consumes if_inst this cycle (combinational)
- rs1_addr, rs2_addr  out  5  register-file read addresses = if_inst[19:15], if_inst[24:20]
- rs1_data, rs2_data  in  32  register-file read data, same cycle
- ex_alu_out  in  32  ALU result of the instruction currently in EX
- wb_valid, wb_reg_write  in  1 each  writeback stage writes wb_rd
- wb_rd  in  5; wb_data  in  32
- ex_stall  in  1  downstream holds EX
- flush  in  1  kill ID and EX contents (taken branch / jump)
- ex_valid  out  1; ex_opcode  out  5 (inst[6:2]); ex_func3  out  3; ex_func7  out  1 (inst[30])
- ex_operand1, ex_operand2  out  32  ALU operands
- ex_rs1_val, ex_rs2_val  out  32  forwarded rs1/rs2 values (jalr target, store data)
- ex_imm  out  32; ex_pc  out  32; ex_rd  out  5; ex_reg_write  out  1; ex_illegal  out  1

## Operation
- Immediates are sign-extended to 32 bits. I: inst[31:20]. S: {inst[31:25],inst[11:7]}. B: {inst[31],inst[7],inst[30:25],inst[11:8],0}. J: {inst[31],inst[19:12],inst[20],inst[30:21],0}. U: {inst[31:12],12'b0}.
- Operand select by opcode:
  - R_type 01100: rs1, rs2.
  - I_Comp 00100: rs1, I-imm.
  - I_Load 00000: rs1, I-imm.
  - Store 01000: rs1, S-imm.
  - B_type 11000: rs1, rs2; ex_imm = B-imm.
  - J_jal 11011: pc, J-imm.
  - I_jalr 11001: pc, I-imm.
  - U_lui 01101: 0, U-imm.
  - U_auipc 00101: pc, U-imm.
- ex_imm always carries the format's immediate.
- ex_reg_write = 1 for R, I_Comp, Load, jal, jalr, lui, auipc with rd != 0; otherwise 0.
- Unknown opcode or inst[1:0] != 2'b11: ex_illegal = 1, ex_reg_write = 0; the instruction still issues.
- rs1 is used by R, I_Comp, Load, Store, B, and jalr. rs2 is used by R, Store, and B. Unused sources never cause stalls.
- Register x0 always reads 0 and is never forwarded.
- Forwarding (FORWARD_EN) priority for a used source rs != 0:
  - EX match (ex_valid, ex_reg_write, ex_rd == rs, EX not a load): use ex_alu_out.
  - Otherwise WB match (wb_valid, wb_reg_write, wb_rd == rs): use wb_data.
  - Otherwise the register-file data.
- Load-use hazard: EX holds a valid load with ex_rd == a used rs. Then id_ready = 0 and a bubble enters EX (ex_valid = 0). The instruction re-evaluates next cycle and gets its value by WB forwarding.
- Control priority: reset > flush > ex_stall > hazard > normal issue.
- Flush: EX loads a bubble, id_ready = 1, and if_inst is discarded. Flush overrides ex_stall.
- ex_stall without flush: all EX registers hold and id_ready = 0.

## Timing
- Latency from an ID accept to valid EX outputs is 1 cycle. Throughput is 1 instruction per cycle when there is no hazard.
- id_ready, rs1_addr and rs2_addr are combinational. All ex_* outputs are registered.
- Reset value of every ex_* output is 0, including ex_valid = 0 and ex_illegal = 0. Reset is asynchronous and takes effect mid-stall or mid-hazard; the first accept is possible in the first cycle after rst_n rises.
- A bubble clears ex_valid, ex_reg_write and ex_illegal. The other ex_* fields are don't-care in a bubble.
- When if_valid = 0 and there is no stall, EX loads a bubble.

## Configuration
- ID_EX_FORWARD_EN defined: forwarding as above. Only the load-use hazard stalls, for 1 cycle.
- ID_EX_FORWARD_EN undefined: no bypass; operands come directly from rs1_data/rs2_data. The stage stalls (bubble into EX) while any used rs != 0 matches a valid writing EX or WB instruction. A back-to-back dependency therefore costs 2 bubbles.

## Test plan
- Reset: hold rst_n = 0 mid-stream → all ex_* outputs are 0 immediately. Release, then issue addi x1,x0,5 → next cycle ex_operand1 = 0, ex_operand2 = 5, ex_rd = 1, ex_reg_write = 1.
- Forwarding: add x3,x1,x2 with EX = addi x1 (ex_alu_out = 7) and WB writing x2 = 9 → ex_operand1 = 7, ex_operand2 = 9. With the macro undefined → 2 bubbles, then rs data is used.
- Load-use: lw x5,0(x4) followed by sub x6,x5,x7 → one cycle with id_ready = 0 and ex_valid = 0. sub then issues with operand1 = wb_data of the load.
- Immediates and operand select:
  - jal x1,-8 at pc 0x100 → operand1 = 0x100, operand2 = 0xFFFFFFF8.
  - lui x2,0x12345 → operand1 = 0, operand2 = 0x12345000.
- Flush and stall: assert flush together with ex_stall → next cycle ex_valid = 0 and the ID instruction is dropped. ex_stall alone for 3 cycles → ex_* stable and id_ready = 0.
- x0 and illegal: add x0,x0,x0 while EX has ex_rd = 0 → no forwarding and ex_reg_write = 0. Opcode 1111111 → ex_illegal = 1.
